// File: rtl/regfile_dump_engine.sv
// regfile_dump_engine: streams register-file entries first..last over a valid/ready port.
// Optional macro DUMP_CHECKSUM_EN adds a modulo-2^XLEN sum of the accepted words.
module regfile_dump_engine #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W-1:0] first_idx,
    input  logic [IDX_W-1:0] last_idx,
    input  logic             abort,
    output logic [IDX_W-1:0] rf_raddr,
    input  logic [XLEN-1:0]  rf_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             err
`ifdef DUMP_CHECKSUM_EN
    ,
    output logic [XLEN-1:0]  checksum
`endif
);
    typedef enum logic [1:0] {IDLE, FETCH, STREAM, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] last;
    logic             legal, hs, at_last, load;

    assign legal   = (first_idx <= last_idx) && (int'(last_idx) < NREGS);
    assign hs      = out_valid && out_ready;
    assign at_last = (rf_raddr == last);
    // rf_raddr always points at the next word to load; it stops at last and never wraps.
    assign load    = !abort && ((state == FETCH) || (state == STREAM && hs && !out_last));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            last      <= '0;
            rf_raddr  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            checksum  <= '0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (state != IDLE && abort) begin
                state     <= IDLE;
                busy      <= 1'b0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            busy <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                            checksum <= '0;
`endif
                            if (legal) begin
                                last     <= last_idx;
                                rf_raddr <= first_idx;
                                state    <= FETCH;
                            end else begin
                                done  <= 1'b1;
                                err   <= 1'b1;
                                state <= DONE;
                            end
                        end
                    end
                    FETCH: state <= STREAM;
                    STREAM: begin
                        if (hs) begin
`ifdef DUMP_CHECKSUM_EN
                            checksum <= checksum + out_data;
`endif
                            if (out_last) begin
                                out_valid <= 1'b0;
                                out_last  <= 1'b0;
                                done      <= 1'b1;
                                state     <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
                if (load) begin
                    out_data  <= rf_rdata;
                    out_idx   <= rf_raddr;
                    out_last  <= at_last;
                    out_valid <= 1'b1;
                    if (!at_last) rf_raddr <= rf_raddr + IDX_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_regfile_dump_engine.sv
// Bench for regfile_dump_engine: table-driven dumps, abort/reset sequences, randomized dumps
// checked against a queue model built from the bench's own register-file array.
module tb_regfile_dump_engine;
    localparam int XLEN = 32, NREGS = 32, IDX_W = 5;

    logic             clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0, out_ready = 1'b0;
    logic [IDX_W-1:0] first_idx = '0, last_idx = '0;
    logic [IDX_W-1:0] rf_raddr, out_idx;
    logic [XLEN-1:0]  rf_rdata, out_data;
    logic             out_valid, out_last, busy, done, err;
`ifdef DUMP_CHECKSUM_EN
    logic [XLEN-1:0]  checksum;
`endif
    logic [XLEN-1:0]  rf [NREGS];
    int               n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;
    assign rf_rdata = rf[rf_raddr];

    regfile_dump_engine #(.XLEN(XLEN), .NREGS(NREGS), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .start(start), .first_idx(first_idx), .last_idx(last_idx),
        .abort(abort), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .busy(busy), .done(done), .err(err)
`ifdef DUMP_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_idx"}, out_idx, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_raddr"}, rf_raddr, 0);
`ifdef DUMP_CHECKSUM_EN
        chk({tag, "_cksum"}, checksum, 0);
`endif
    endtask

    // rmode: 0 = ready high, 1 = ready pattern 1,0,0,..., 2 = random ready
    task automatic do_dump(input int f, input int l, input int rmode,
                           output int nb, output logic gerr, output logic [XLEN-1:0] gsum);
        logic [XLEN-1:0]  q[$];
        int               qi[$];
        logic [XLEN-1:0]  msum, acc, hd;
        logic [IDX_W-1:0] hi;
        logic             gdone, held, legal;
        int               cyc, first_v, done_cyc, last_hs;
        legal = (f <= l) && (l < NREGS);
        msum = '0;
        if (legal) for (int i = f; i <= l; i++) begin
            q.push_back(rf[i]); qi.push_back(i); msum += rf[i];
        end
        nb = 0; gerr = 0; acc = '0; gdone = 0; held = 0; cyc = 0;
        first_v = -1; done_cyc = -1; last_hs = -1; hd = '0; hi = '0;
        @(posedge clk); #1 start = 1'b1; first_idx = IDX_W'(f); last_idx = IDX_W'(l);
        @(posedge clk); #1 start = 1'b0;
        while (!gdone && cyc < 400) begin
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (held) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, hd);
                chk("stall_idx", out_idx, hi);
            end
            held = out_valid && !out_ready; hd = out_data; hi = out_idx;
            if (out_valid && first_v < 0) first_v = cyc;
            if (legal && busy) chk("raddr_le_last", rf_raddr <= l, 1);
            if (out_valid && out_ready) begin
                if (qi.size() == 0) chk("extra_beat", 1, 0);
                else begin
                    chk("beat_idx", out_idx, qi[0]);
                    chk("beat_data", out_data, q[0]);
                    chk("beat_last", out_last, qi.size() == 1);
                    void'(qi.pop_front()); void'(q.pop_front());
                end
                acc += out_data; nb++; last_hs = cyc;
            end
            if (done) begin
                gdone = 1; gerr = err; done_cyc = cyc;
                chk("busy_in_done", busy, 1);
                chk("valid_in_done", out_valid, 0);
            end
            @(posedge clk); #1 cyc++;
        end
        out_ready = 1'b0;
        chk("done_seen", gdone, 1);
        chk("beats_left", qi.size(), 0);
        if (legal) begin
            chk("first_valid_lat", first_v, 1);
            chk("done_after_last", done_cyc, last_hs + 1);
        end else begin
            chk("err_done_lat", done_cyc, 0);
            chk("err_no_beats", first_v, -1);
        end
        chk("idle_busy", busy, 0);
        chk("done_pulse", done, 0);
`ifdef DUMP_CHECKSUM_EN
        gsum = checksum;
`else
        gsum = acc;
`endif
        chk("sum_model", gsum, msum);
    endtask

    typedef struct {
        int              f, l, rmode, beats;
        logic            e;
        logic [XLEN-1:0] sum;
    } vec_t;

    vec_t            tbl[8];
    int              nb, exp_nb, f, l;
    logic            ge, found;
    logic [XLEN-1:0] gs;

    initial begin
        tbl[0] = '{1, 4, 0, 4, 1'b0, 32'd10};
        tbl[1] = '{1, 4, 1, 4, 1'b0, 32'd10};
        tbl[2] = '{5, 2, 0, 0, 1'b1, 32'd0};
        tbl[3] = '{0, 31, 0, 32, 1'b0, 32'd496};
        tbl[4] = '{7, 7, 1, 1, 1'b0, 32'd7};
        tbl[5] = '{31, 31, 0, 1, 1'b0, 32'd31};
        tbl[6] = '{30, 31, 2, 2, 1'b0, 32'd61};
        tbl[7] = '{0, 31, 2, 32, 1'b0, 32'd496};
        for (int i = 0; i < NREGS; i++) rf[i] = XLEN'(i);

        repeat (2) @(posedge clk);
        @(negedge clk) chk_zero("reset");
        rst = 1'b1;
        // abort in IDLE is a no-op
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        chk("idle_abort_busy", busy, 0);

        foreach (tbl[i]) begin
            do_dump(tbl[i].f, tbl[i].l, tbl[i].rmode, nb, ge, gs);
            chk($sformatf("tbl%0d_beats", i), nb, tbl[i].beats);
            chk($sformatf("tbl%0d_err", i), ge, tbl[i].e);
            chk($sformatf("tbl%0d_sum", i), gs, tbl[i].sum);
        end

        // abort while beat idx3 of a 1..8 dump is pending
        @(posedge clk); #1 start = 1'b1; first_idx = 5'd1; last_idx = 5'd8; out_ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            if (out_valid && out_idx == 5'd3) found = 1;
            else begin @(posedge clk); #1; end
        end
        chk("abort_beat_found", found, 1);
        abort = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk) chk("abort_no_done", done | out_valid | busy, 0);
        end
        do_dump(0, 0, 0, nb, ge, gs);
        chk("post_abort_beats", nb, 1);

        // reset in the middle of a full dump; start with abort in IDLE also checks start wins
        @(posedge clk); #1 start = 1'b1; first_idx = 5'd0; last_idx = 5'd31; out_ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1 chk_zero("midrst");
        rst = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1 start = 1'b1; abort = 1'b1; first_idx = 5'd2; last_idx = 5'd3;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        chk("start_beats_abort", busy, 1);
        repeat (4) @(posedge clk);
        #1 chk("start_wins_done_wait", busy, 1);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("start_wins_finish", busy, 0);
        do_dump(2, 3, 0, nb, ge, gs);
        chk("post_rst_beats", nb, 2);
        chk("post_rst_sum", gs, 5);

        // randomized contents, ranges and backpressure
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < NREGS; i++) rf[i] = $urandom;
            f = $urandom_range(0, NREGS - 1);
            l = (it % 3 == 0) ? f + $urandom_range(0, 2) : $urandom_range(0, NREGS - 1);
            if (l > NREGS - 1) l = NREGS - 1;
            exp_nb = (f <= l) ? l - f + 1 : 0;
            do_dump(f, l, 2, nb, ge, gs);
            chk($sformatf("rnd%0d_beats", it), nb, exp_nb);
            chk($sformatf("rnd%0d_err", it), ge, f > l);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
